// File: rtl/usrt_pkg.sv
// Shared receive/transmit definitions: FSM state encodings, default frame geometry
// and the parity helper used by the optional parity stage.
package usrt_pkg;

    localparam int C_OVERSAMPLE = 16;
    localparam int C_DATA_BITS  = 8;

    typedef logic [2:0] usrt_state_t;

    localparam usrt_state_t ST_IDLE   = 3'd0;
    localparam usrt_state_t ST_START  = 3'd1;
    localparam usrt_state_t ST_DATA   = 3'd2;
    localparam usrt_state_t ST_PARITY = 3'd3;
    localparam usrt_state_t ST_STOP   = 3'd4;
    localparam usrt_state_t ST_BREAK  = 3'd5;

    // Returns 1 when the vector holds an odd number of ones (even-parity violation).
    function automatic logic parity_odd(input logic [31:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/usrt_sync.sv
// Multi-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module usrt_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] stage_r;

    // Shift chain; reset to 1 so a reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_r <= {SYNC_STAGES{1'b1}};
        end else begin
            stage_r <= {stage_r[SYNC_STAGES-2:0], din};
        end
    end

    assign dout = stage_r[SYNC_STAGES-1];

endmodule

// File: rtl/usrt_rx_frame.sv
// Oversampling async receiver: start validation, mid-bit sampling, stop check, holding register.
// Define USRT_RX_PARITY_EN to add an even-parity bit and the o_Parity_Err output.
module usrt_rx_frame
    import usrt_pkg::*;
#(
    parameter int DATA_BITS   = C_DATA_BITS,
    parameter int OVERSAMPLE  = C_OVERSAMPLE,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i_Pclk,
    input  logic                 i_Rst,
    input  logic                 i_Os_Tick,
    input  logic                 i_Enable,
    input  logic                 i_Rx_Serial,
    output logic [DATA_BITS-1:0] o_Data,
    output logic                 o_Valid,
    input  logic                 i_Ready,
    output logic                 o_Busy,
    output logic                 o_Frame_Err,
`ifdef USRT_RX_PARITY_EN
    output logic                 o_Overrun,
    output logic                 o_Parity_Err
`else
    output logic                 o_Overrun
`endif
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_ONE  = BW'(1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic                 rx_s;
    usrt_state_t          state_r, state_nx_s;
    logic [CW-1:0]        cnt_r, cnt_nx_s;
    logic [BW-1:0]        bit_r, bit_nx_s;
    logic [DATA_BITS-1:0] shift_r, shift_nx_s;
    logic                 stop_ok_s, stop_bad_s, consume_s;
`ifdef USRT_RX_PARITY_EN
    logic                 par_bad_r, par_bad_nx_s, par_err_s;
`endif

    usrt_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk  (i_Pclk),
        .rst  (i_Rst),
        .din  (i_Rx_Serial),
        .dout (rx_s)
    );

    // Next-state logic; everything advances only on oversample ticks, disable wins.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        bit_nx_s   = bit_r;
        shift_nx_s = shift_r;
        stop_ok_s  = 1'b0;
        stop_bad_s = 1'b0;
`ifdef USRT_RX_PARITY_EN
        par_bad_nx_s = par_bad_r;
        par_err_s    = 1'b0;
`endif
        if (!i_Enable) begin
            state_nx_s = ST_IDLE;
            cnt_nx_s   = {CW{1'b0}};
            bit_nx_s   = {BW{1'b0}};
        end else if (i_Os_Tick) begin
            case (state_r)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_nx_s = ST_START;
                        cnt_nx_s   = {CW{1'b0}};
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (cnt_r == CNT_HALF) begin
                        cnt_nx_s   = {CW{1'b0}};
                        bit_nx_s   = {BW{1'b0}};
                        state_nx_s = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_nx_s = cnt_r + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (cnt_r == CNT_FULL) begin
                        cnt_nx_s   = {CW{1'b0}};
                        shift_nx_s = DATA_BITS'({rx_s, shift_r} >> 1);
                        if (bit_r == BIT_LAST) begin
                            bit_nx_s = {BW{1'b0}};
`ifdef USRT_RX_PARITY_EN
                            state_nx_s = ST_PARITY;
`else
                            state_nx_s = ST_STOP;
`endif
                        end else begin
                            bit_nx_s = bit_r + BIT_ONE;
                        end
                    end else begin
                        cnt_nx_s = cnt_r + CNT_ONE;
                    end
                end
`ifdef USRT_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt_r == CNT_FULL) begin
                        cnt_nx_s     = {CW{1'b0}};
                        par_bad_nx_s = parity_odd(32'({shift_r, rx_s}));
                        state_nx_s   = ST_STOP;
                    end else begin
                        cnt_nx_s = cnt_r + CNT_ONE;
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt_r == CNT_FULL) begin
                        cnt_nx_s   = {CW{1'b0}};
                        stop_ok_s  = rx_s;
                        stop_bad_s = !rx_s;
                        state_nx_s = rx_s ? ST_IDLE : ST_BREAK;
`ifdef USRT_RX_PARITY_EN
                        par_err_s  = par_bad_r;
`endif
                    end else begin
                        cnt_nx_s = cnt_r + CNT_ONE;
                    end
                end
                ST_BREAK: begin
                    state_nx_s = rx_s ? ST_IDLE : ST_BREAK;
                end
                default: begin
                    state_nx_s = ST_IDLE;
                    cnt_nx_s   = {CW{1'b0}};
                    bit_nx_s   = {BW{1'b0}};
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    // FSM state, counters, shift register and registered status pulses.
    always_ff @(posedge i_Pclk) begin
        if (i_Rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CW{1'b0}};
            bit_r       <= {BW{1'b0}};
            shift_r     <= {DATA_BITS{1'b0}};
            o_Busy      <= 1'b0;
            o_Frame_Err <= 1'b0;
`ifdef USRT_RX_PARITY_EN
            par_bad_r    <= 1'b0;
            o_Parity_Err <= 1'b0;
`endif
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            bit_r       <= bit_nx_s;
            shift_r     <= shift_nx_s;
            o_Busy      <= (state_nx_s != ST_IDLE);
            o_Frame_Err <= stop_bad_s;
`ifdef USRT_RX_PARITY_EN
            par_bad_r    <= par_bad_nx_s;
            o_Parity_Err <= par_err_s;
`endif
        end
    end

    assign consume_s = o_Valid & i_Ready;

    // Holding register: a load coinciding with a consume replaces the byte without overrun.
    always_ff @(posedge i_Pclk) begin
        if (i_Rst) begin
            o_Data    <= {DATA_BITS{1'b0}};
            o_Valid   <= 1'b0;
            o_Overrun <= 1'b0;
        end else begin
            if (stop_ok_s && (!o_Valid || consume_s)) begin
                o_Data  <= shift_r;
                o_Valid <= 1'b1;
            end else if (consume_s) begin
                o_Valid <= 1'b0;
            end else begin
                o_Valid <= o_Valid;
            end
            if (consume_s) begin
                o_Overrun <= 1'b0;
            end else if (stop_ok_s && o_Valid) begin
                o_Overrun <= 1'b1;
            end else begin
                o_Overrun <= o_Overrun;
            end
        end
    end

endmodule

// File: tb/tb_usrt_rx_frame.sv
// Directed bench for usrt_rx_frame; tick every 4 clocks, 16 ticks per bit.
module tb_usrt_rx_frame;

`ifdef USRT_RX_PARITY_EN
    localparam int STOP_TICK = 169;
`else
    localparam int STOP_TICK = 153;
`endif
    // Stop sample lands on the STOP_TICK-th tick after the start edge is driven.
    localparam int LAT = 4 * STOP_TICK;

    logic       clk = 1'b0;
    logic       rst, os_tick, enable, rx, ready;
    logic [7:0] o_Data;
    logic       o_Valid, o_Busy, o_Frame_Err, o_Overrun;
`ifdef USRT_RX_PARITY_EN
    logic       o_Parity_Err;
    int         perr_cnt, perr_cyc;
`endif

    int   checks = 0;
    int   failures = 0;
    int   cyc_n = 0;
    int   valid_rises, valid_rise_cyc, ferr_cnt, ferr_cyc, start_cyc;
    logic prev_valid, busy_seen;

    usrt_rx_frame dut (
        .i_Pclk      (clk),
        .i_Rst       (rst),
        .i_Os_Tick   (os_tick),
        .i_Enable    (enable),
        .i_Rx_Serial (rx),
        .o_Data      (o_Data),
        .o_Valid     (o_Valid),
        .i_Ready     (ready),
        .o_Busy      (o_Busy),
        .o_Frame_Err (o_Frame_Err),
`ifdef USRT_RX_PARITY_EN
        .o_Overrun   (o_Overrun),
        .o_Parity_Err(o_Parity_Err)
`else
        .o_Overrun   (o_Overrun)
`endif
    );

    always #5 clk = ~clk;

    task automatic cycle(input logic tk);
        os_tick = tk;
        @(posedge clk);
        #1;
        cyc_n++;
        if (o_Valid && !prev_valid) begin
            valid_rises++;
            if (valid_rise_cyc < 0) valid_rise_cyc = cyc_n;
        end
        prev_valid = o_Valid;
        if (o_Frame_Err) begin ferr_cnt++; ferr_cyc = cyc_n; end
        if (o_Busy) busy_seen = 1'b1;
`ifdef USRT_RX_PARITY_EN
        if (o_Parity_Err) begin perr_cnt++; perr_cyc = cyc_n; end
`endif
    endtask

    task automatic tick_period();
        cycle(1'b0); cycle(1'b0); cycle(1'b0); cycle(1'b1);
        os_tick = 1'b0;
    endtask

    task automatic send_bits(input logic b, input int n);
        rx = b;
        repeat (n) tick_period();
    endtask

    task automatic clear_mon();
        valid_rises = 0; valid_rise_cyc = -1; ferr_cnt = 0; ferr_cyc = -1;
        busy_seen = 1'b0; prev_valid = o_Valid; start_cyc = cyc_n;
`ifdef USRT_RX_PARITY_EN
        perr_cnt = 0; perr_cyc = -1;
`endif
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bits(1'b0, 16);
        for (int i = 0; i < 8; i++) send_bits(d[i], 16);
`ifdef USRT_RX_PARITY_EN
        send_bits(^d, 16);
`endif
        send_bits(stop, 16);
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; ready = 1'b0; rx = 1'b1; os_tick = 1'b0;
        cycle(1'b0); cycle(1'b0);
        checks++; if (o_Valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", o_Valid); end
        checks++; if (o_Data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", o_Data); end
        checks++; if (o_Busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", o_Busy); end
        checks++; if (o_Frame_Err !== 1'b0) begin failures++; $display("FAIL reset_ferr: got %b expected 0", o_Frame_Err); end
        checks++; if (o_Overrun !== 1'b0) begin failures++; $display("FAIL reset_ovr: got %b expected 0", o_Overrun); end
        rst = 1'b0; enable = 1'b1;
        send_bits(1'b1, 4);
    endtask

    task automatic test_frame_53();
        ready = 1'b1;
        clear_mon();
        send_frame(8'h53, 1'b1);
        send_bits(1'b1, 4);
        checks++; if (valid_rise_cyc !== start_cyc + LAT) begin failures++; $display("FAIL f53_latency: got %0d expected %0d", valid_rise_cyc - start_cyc, LAT); end
        checks++; if (o_Data !== 8'h53) begin failures++; $display("FAIL f53_data: got %h expected 53", o_Data); end
        checks++; if (valid_rises !== 1) begin failures++; $display("FAIL f53_pulses: got %0d expected 1", valid_rises); end
        checks++; if (o_Valid !== 1'b0) begin failures++; $display("FAIL f53_consumed: got %b expected 0", o_Valid); end
        checks++; if (ferr_cnt !== 0) begin failures++; $display("FAIL f53_ferr: got %0d expected 0", ferr_cnt); end
    endtask

    task automatic test_glitch();
        clear_mon();
        send_bits(1'b0, 4);
        send_bits(1'b1, 16);
        checks++; if (busy_seen !== 1'b1) begin failures++; $display("FAIL glitch_seen: got %b expected 1", busy_seen); end
        checks++; if (o_Busy !== 1'b0) begin failures++; $display("FAIL glitch_idle: got %b expected 0", o_Busy); end
        checks++; if (valid_rises !== 0) begin failures++; $display("FAIL glitch_valid: got %0d expected 0", valid_rises); end
        checks++; if (ferr_cnt !== 0) begin failures++; $display("FAIL glitch_ferr: got %0d expected 0", ferr_cnt); end
    endtask

    task automatic test_framing();
        clear_mon();
        send_frame(8'hA5, 1'b0);
        send_bits(1'b0, 32);
        checks++; if (ferr_cnt !== 1) begin failures++; $display("FAIL ferr_pulses: got %0d expected 1", ferr_cnt); end
        checks++; if (ferr_cyc !== start_cyc + LAT) begin failures++; $display("FAIL ferr_time: got %0d expected %0d", ferr_cyc - start_cyc, LAT); end
        checks++; if (valid_rises !== 0) begin failures++; $display("FAIL ferr_novalid: got %0d expected 0", valid_rises); end
        checks++; if (o_Busy !== 1'b1) begin failures++; $display("FAIL ferr_break: got %b expected 1", o_Busy); end
        send_bits(1'b1, 4);
        checks++; if (o_Busy !== 1'b0) begin failures++; $display("FAIL break_exit: got %b expected 0", o_Busy); end
        clear_mon();
        send_frame(8'h3C, 1'b1);
        send_bits(1'b1, 4);
        checks++; if (o_Data !== 8'h3C) begin failures++; $display("FAIL after_break_data: got %h expected 3c", o_Data); end
        checks++; if (valid_rises !== 1) begin failures++; $display("FAIL after_break_valid: got %0d expected 1", valid_rises); end
        checks++; if (ferr_cnt !== 0) begin failures++; $display("FAIL after_break_ferr: got %0d expected 0", ferr_cnt); end
    endtask

    task automatic test_overrun();
        ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_bits(1'b1, 4);
        send_frame(8'h22, 1'b1);
        send_bits(1'b1, 4);
        checks++; if (o_Data !== 8'h11) begin failures++; $display("FAIL ovr_data: got %h expected 11", o_Data); end
        checks++; if (o_Valid !== 1'b1) begin failures++; $display("FAIL ovr_valid: got %b expected 1", o_Valid); end
        checks++; if (o_Overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag: got %b expected 1", o_Overrun); end
        ready = 1'b1;
        cycle(1'b0);
        ready = 1'b0;
        checks++; if (o_Valid !== 1'b0) begin failures++; $display("FAIL ovr_consume_valid: got %b expected 0", o_Valid); end
        checks++; if (o_Overrun !== 1'b0) begin failures++; $display("FAIL ovr_consume_flag: got %b expected 0", o_Overrun); end
    endtask

    task automatic test_abort();
        ready = 1'b1;
        clear_mon();
        send_bits(1'b0, 16);
        send_bits(1'b1, 16); send_bits(1'b0, 16); send_bits(1'b1, 16);
        send_bits(1'b0, 8);
        checks++; if (o_Busy !== 1'b1) begin failures++; $display("FAIL abort_pre_busy: got %b expected 1", o_Busy); end
        enable = 1'b0;
        cycle(1'b0);
        checks++; if (o_Busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", o_Busy); end
        send_bits(1'b1, 16);
        enable = 1'b1;
        send_bits(1'b1, 16);
        checks++; if (valid_rises !== 0) begin failures++; $display("FAIL abort_valid: got %0d expected 0", valid_rises); end
        checks++; if (ferr_cnt !== 0) begin failures++; $display("FAIL abort_ferr: got %0d expected 0", ferr_cnt); end
    endtask

    task automatic test_reset_mid();
        ready = 1'b0;
        send_frame(8'h81, 1'b1);
        send_bits(1'b1, 4);
        checks++; if (o_Valid !== 1'b1) begin failures++; $display("FAIL rmid_pre_valid: got %b expected 1", o_Valid); end
        send_bits(1'b0, 16);
        send_bits(1'b1, 16);
        send_bits(1'b0, 8);
        rst = 1'b1;
        cycle(1'b0);
        checks++; if (o_Valid !== 1'b0) begin failures++; $display("FAIL rmid_valid: got %b expected 0", o_Valid); end
        checks++; if (o_Data !== 8'h00) begin failures++; $display("FAIL rmid_data: got %h expected 00", o_Data); end
        checks++; if (o_Busy !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %b expected 0", o_Busy); end
        checks++; if (o_Overrun !== 1'b0) begin failures++; $display("FAIL rmid_ovr: got %b expected 0", o_Overrun); end
        checks++; if (dut.rx_s !== 1'b1) begin failures++; $display("FAIL rmid_sync: got %b expected 1", dut.rx_s); end
        rst = 1'b0;
        send_bits(1'b1, 8);
    endtask

`ifdef USRT_RX_PARITY_EN
    task automatic test_parity();
        ready = 1'b1;
        clear_mon();
        send_bits(1'b0, 16);
        for (int i = 0; i < 8; i++) send_bits((i < 3) ? 1'b1 : 1'b0, 16);
        send_bits(1'b0, 16);
        send_bits(1'b1, 16);
        send_bits(1'b1, 4);
        checks++; if (perr_cnt !== 1) begin failures++; $display("FAIL par_pulses: got %0d expected 1", perr_cnt); end
        checks++; if (perr_cyc !== start_cyc + LAT) begin failures++; $display("FAIL par_time: got %0d expected %0d", perr_cyc - start_cyc, LAT); end
        checks++; if (o_Data !== 8'h07) begin failures++; $display("FAIL par_data: got %h expected 07", o_Data); end
        checks++; if (valid_rises !== 1) begin failures++; $display("FAIL par_valid: got %0d expected 1", valid_rises); end
    endtask
`endif

    initial begin
        test_reset();
        test_frame_53();
        test_glitch();
        test_framing();
        test_overrun();
        test_abort();
        test_reset_mid();
`ifdef USRT_RX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
